// File: rtl/dac_seg_pkg.sv
// rtl/dac_seg_pkg.sv - shared constants, types and unary decode helper for the DAC segment encoder
package dac_seg_pkg;

    localparam int NBIN      = 7;
    localparam int NTHERM    = 17;
    localparam int DIN_W     = 12;
    localparam int SAT_CNT_W = 8;
    localparam int CNT_W     = DIN_W - NBIN;   // holds the raw MSB field 0..31
    localparam int PTR_W     = 5;              // DWA pointer 0..NTHERM-1

    // Largest representable output: NTHERM full unary elements plus a full binary field.
    localparam int FULL_SCALE = NTHERM * (2 ** NBIN) + (2 ** NBIN) - 1;

    localparam real VDD_REF = 0.8;
    localparam real VDD_TOL = 0.05;
    localparam real VDD_MIN = VDD_REF * (1.0 - VDD_TOL);
    localparam real VDD_MAX = VDD_REF * (1.0 + VDD_TOL);

    typedef logic [NBIN-1:0]   bin_t;
    typedef logic [NTHERM-1:0] therm_t;
    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [PTR_W-1:0]  ptr_t;

    // Element i is on when its distance above ptr (mod NTHERM) is below count.
    // ptr = 0 degenerates to a plain thermometer filled from bit 0.
    function automatic therm_t therm_rotate(input cnt_t count, input ptr_t ptr);
        therm_t t;
        int     off;
        t = '0;
        for (int i = 0; i < NTHERM; i++) begin
            off  = (i + NTHERM - int'(ptr)) % NTHERM;
            t[i] = (off < int'(count));
        end
        return t;
    endfunction

endpackage

// File: rtl/dac_dwa_rotator.sv
// rtl/dac_dwa_rotator.sv - data-weighted averaging pointer and rotated unary decode
//
// Ports:
//   clk, rstb : sample clock, asynchronous active-low reset
//   clr       : synchronous pointer clear (power-down / bad supply)
//   adv       : advance the pointer by count at this edge (valid S2 update)
//   count     : clipped unary count 0..NTHERM
//   therm     : rotated unary word for the current pointer (combinational)
module dac_dwa_rotator
    import dac_seg_pkg::*;
(
    input  logic   clk,
    input  logic   rstb,
    input  logic   clr,
    input  logic   adv,
    input  cnt_t   count,
    output therm_t therm
);

    localparam logic [PTR_W:0] NTHERM_W = (PTR_W + 1)'(NTHERM);

    ptr_t           ptr;
    logic [PTR_W:0] sum;
    ptr_t           ptr_next;

    assign therm = therm_rotate(count, ptr);

    // ptr <= NTHERM-1 and count <= NTHERM, so one conditional subtract is a full modulo;
    // count of 0 or NTHERM leaves the pointer where it was.
    assign sum      = {1'b0, ptr} + {1'b0, count};
    assign ptr_next = (sum >= NTHERM_W) ? ptr_t'(sum - NTHERM_W) : ptr_t'(sum);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/dac_segment_encoder.sv
// rtl/dac_segment_encoder.sv - segmented DAC front end: clip, split, unary/binary decode, power gating
//
// Optional feature macro: DAC_SEGMENT_ENCODER_DWA_EN (data-weighted averaging on the unary field).
//
// Ports:
//   clk, rstb              : sample clock, asynchronous active-low reset
//   pdb                    : 0 = powered down (sampled on clk)
//   vddana_0p8             : supply level in volts
//   din_vld, din           : input sample and its valid
//   databin, databinb      : binary LSB field and complement
//   datatherm, datathermb  : unary MSB field and complement
//   dout_vld               : output word valid (2 clk after input)
//   sat_flag, sat_cnt      : sticky clip indicator and saturating clip count
module dac_segment_encoder
    import dac_seg_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 pdb,
    input  real                  vddana_0p8,
    input  logic                 din_vld,
    input  logic [DIN_W-1:0]     din,
    output bin_t                 databin,
    output bin_t                 databinb,
    output therm_t               datatherm,
    output therm_t               datathermb,
    output logic                 dout_vld,
    output logic                 sat_flag,
    output logic [SAT_CNT_W-1:0] sat_cnt
);

    localparam cnt_t MSB_CLIP = cnt_t'(FULL_SCALE / (2 ** NBIN));
    localparam bin_t LSB_CLIP = bin_t'(FULL_SCALE % (2 ** NBIN));

    logic   supply_ok;
    logic   active;
    logic   supply_bad_q;

    cnt_t   msb_in;
    logic   over;
    cnt_t   msb_c_in;
    bin_t   lsb_c_in;

    logic   s1_vld;
    cnt_t   s1_msb;
    bin_t   s1_lsb;
    logic   s1_sat;

    therm_t therm_next;

    assign supply_ok = (vddana_0p8 >= VDD_MIN) && (vddana_0p8 <= VDD_MAX);
    // Power-down and a bad supply are treated identically.
    assign active    = pdb && supply_ok;

    assign msb_in   = din[DIN_W-1:NBIN];
    assign over     = msb_in > MSB_CLIP;
    assign msb_c_in = over ? MSB_CLIP : msb_in;
    assign lsb_c_in = over ? LSB_CLIP : din[NBIN-1:0];

    // S1: clipped code, clip indication and valid.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            s1_vld <= 1'b0;
            s1_msb <= '0;
            s1_lsb <= '0;
            s1_sat <= 1'b0;
        end else if (!active) begin
            s1_vld <= 1'b0;
            s1_msb <= '0;
            s1_lsb <= '0;
            s1_sat <= 1'b0;
        end else begin
            s1_vld <= din_vld;
            if (din_vld) begin
                s1_msb <= msb_c_in;
                s1_lsb <= lsb_c_in;
                s1_sat <= over;
            end
        end
    end

`ifdef DAC_SEGMENT_ENCODER_DWA_EN
    dac_dwa_rotator u_dwa_rotator (
        .clk   (clk),
        .rstb  (rstb),
        .clr   (!active),
        .adv   (active && s1_vld),
        .count (s1_msb),
        .therm (therm_next)
    );
`else
    assign therm_next = therm_rotate(s1_msb, '0);
`endif

    // S2: registered driver words. Clip statistics update with the word they describe,
    // so a sample flushed by power-down is never counted.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            databin    <= '0;
            databinb   <= '1;
            datatherm  <= '0;
            datathermb <= '1;
            dout_vld   <= 1'b0;
            sat_flag   <= 1'b0;
            sat_cnt    <= '0;
        end else if (!active) begin
            // True and complement both low: every driver switch off.
            databin    <= '0;
            databinb   <= '0;
            datatherm  <= '0;
            datathermb <= '0;
            dout_vld   <= 1'b0;
        end else if (s1_vld) begin
            databin    <= s1_lsb;
            databinb   <= ~s1_lsb;
            datatherm  <= therm_next;
            datathermb <= ~therm_next;
            dout_vld   <= 1'b1;
            if (s1_sat) begin
                sat_flag <= 1'b1;
                if (sat_cnt != '1) begin
                    sat_cnt <= sat_cnt + 1'b1;
                end
            end
        end else begin
            dout_vld <= 1'b0;
        end
    end

    // One warning per entry into the bad-supply state.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            supply_bad_q <= 1'b0;
        end else begin
            supply_bad_q <= !supply_ok;
            if (!supply_ok && !supply_bad_q) begin
                $warning("dac_segment_encoder: vddana_0p8 out of range, outputs gated");
            end
        end
    end

endmodule

// File: tb/tb_dac_segment_encoder.sv
// tb/tb_dac_segment_encoder.sv - randomized self-checking bench with behavioural reference model
module tb_dac_segment_encoder;

    logic        clk     = 1'b0;
    logic        rstb    = 1'b1;
    logic        pdb     = 1'b1;
    logic        din_vld = 1'b0;
    logic [11:0] din     = 12'h000;
    real         vdd     = 0.8;

    logic [6:0]  databin, databinb;
    logic [16:0] datatherm, datathermb;
    logic        dout_vld, sat_flag;
    logic [7:0]  sat_cnt;

    dac_segment_encoder dut (
        .clk        (clk),
        .rstb       (rstb),
        .pdb        (pdb),
        .vddana_0p8 (vdd),
        .din_vld    (din_vld),
        .din        (din),
        .databin    (databin),
        .databinb   (databinb),
        .datatherm  (datatherm),
        .datathermb (datathermb),
        .dout_vld   (dout_vld),
        .sat_flag   (sat_flag),
        .sat_cnt    (sat_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int m_bin = 0, m_binb = 'h7F, m_therm = 0, m_thermb = 'h1FFFF;
    int m_vld = 0, m_flag = 0, m_cnt = 0, m_ptr = 0;
    bit prev_acc = 0;
    int prev_din = 0;
    int mm, ml, th;
    bit msat;

    function automatic bit sok(input real v);
        return (v >= 0.76) && (v <= 0.84);
    endfunction

    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            m_bin = 0; m_binb = 'h7F; m_therm = 0; m_thermb = 'h1FFFF;
            m_vld = 0; m_flag = 0; m_cnt = 0; m_ptr = 0; prev_acc = 0;
        end else if (!(pdb && sok(vdd))) begin
            m_bin = 0; m_binb = 0; m_therm = 0; m_thermb = 0;
            m_vld = 0; m_ptr = 0; prev_acc = 0;
        end else begin
            if (prev_acc) begin
                mm = prev_din / 128;
                ml = prev_din % 128;
                msat = (mm > 17);
                if (msat) begin mm = 17; ml = 127; end
`ifdef DAC_SEGMENT_ENCODER_DWA_EN
                th = 0;
                for (int j = 0; j < mm; j++) th = th | (1 << ((m_ptr + j) % 17));
                m_ptr = (m_ptr + mm) % 17;
`else
                th = (1 << mm) - 1;
`endif
                m_bin = ml; m_binb = (~ml) & 'h7F;
                m_therm = th; m_thermb = (~th) & 'h1FFFF;
                m_vld = 1;
                if (msat) begin
                    m_flag = 1;
                    if (m_cnt < 255) m_cnt++;
                end
            end else begin
                m_vld = 0;
            end
            prev_acc = din_vld;
            prev_din = int'(din);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("databin",    32'(databin),    32'(m_bin));
            check("databinb",   32'(databinb),   32'(m_binb));
            check("datatherm",  32'(datatherm),  32'(m_therm));
            check("datathermb", 32'(datathermb), 32'(m_thermb));
            check("dout_vld",   32'(dout_vld),   32'(m_vld));
            check("sat_flag",   32'(sat_flag),   32'(m_flag));
            check("sat_cnt",    32'(sat_cnt),    32'(m_cnt));
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic one_sample(input logic [11:0] d);
        @(posedge clk); #1; din_vld = 1'b1; din = d;
        @(posedge clk); #1; din_vld = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_off(input string tag);
        check({tag, "_bin"},    32'(databin),    32'h0);
        check({tag, "_binb"},   32'(databinb),   32'h0);
        check({tag, "_therm"},  32'(datatherm),  32'h0);
        check({tag, "_thermb"}, 32'(datathermb), 32'h0);
        check({tag, "_vld"},    32'(dout_vld),   32'h0);
    endtask

    initial begin
        #1 rstb = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_bin",    32'(databin),    32'h0);
        check("rst_binb",   32'(databinb),   32'h7F);
        check("rst_therm",  32'(datatherm),  32'h0);
        check("rst_thermb", 32'(datathermb), 32'h1FFFF);
        check("rst_vld",    32'(dout_vld),   32'h0);
        check("rst_flag",   32'(sat_flag),   32'h0);
        check("rst_cnt",    32'(sat_cnt),    32'h0);
        chk_en = 1;
        @(posedge clk); #1 rstb = 1'b1;

        one_sample(12'h000);
        check("zero_bin",    32'(databin),    32'h0);
        check("zero_binb",   32'(databinb),   32'h7F);
        check("zero_therm",  32'(datatherm),  32'h0);
        check("zero_thermb", 32'(datathermb), 32'h1FFFF);
        check("zero_vld",    32'(dout_vld),   32'h1);

        one_sample(12'h2A5);
        check("s2a5_bin",    32'(databin),    32'h25);
        check("s2a5_binb",   32'(databinb),   32'h5A);
        check("s2a5_therm",  32'(datatherm),  32'h1F);
        check("s2a5_thermb", 32'(datathermb), 32'h1FFE0);

        one_sample(12'hFFF);
        check("fs_bin",   32'(databin),   32'h7F);
        check("fs_therm", 32'(datatherm), 32'h1FFFF);
        check("fs_flag",  32'(sat_flag),  32'h1);
        check("fs_cnt",   32'(sat_cnt),   32'h1);

        @(posedge clk); #1 din_vld = 1'b1;
        for (int i = 0; i < 300; i++) begin
            din = 12'(2304 + $urandom_range(0, 1791));
            @(posedge clk); #1;
        end
        din_vld = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("sat_hold_cnt",  32'(sat_cnt),  32'd255);
        check("sat_hold_flag", 32'(sat_flag), 32'h1);

`ifdef DAC_SEGMENT_ENCODER_DWA_EN
        @(posedge clk); #1 pdb = 1'b0;
        @(posedge clk); #1 pdb = 1'b1;
        one_sample(12'(5 * 128));
        check("dwa_a", 32'(datatherm), 32'h0001F);
        one_sample(12'(5 * 128));
        check("dwa_b", 32'(datatherm), 32'h003E0);
        one_sample(12'(10 * 128));
        check("dwa_c", 32'(datatherm), 32'h1FC07);
        one_sample(12'(1 * 128));
        check("dwa_ptr3", 32'(datatherm), 32'h00008);
`endif

        // power-down mid-stream
        @(posedge clk); #1 din_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din = 12'($urandom_range(0, 4095));
            @(posedge clk); #1;
        end
        pdb = 1'b0;
        @(posedge clk); @(negedge clk);
        check_off("pd");
        @(posedge clk); @(posedge clk); #1;
        pdb = 1'b1; din_vld = 1'b1; din = 12'h2A5;
        @(posedge clk); @(negedge clk);
        check("pd_rec_early_vld", 32'(dout_vld), 32'h0);
        #1 din_vld = 1'b0;
        @(posedge clk); @(negedge clk);
        check("pd_rec_vld",   32'(dout_vld),  32'h1);
        check("pd_rec_bin",   32'(databin),   32'h25);
        check("pd_rec_therm", 32'(datatherm), 32'h1F);

        // supply excursion
        @(posedge clk); #1 vdd = 0.70; din_vld = 1'b1; din = 12'h555;
        @(posedge clk); @(negedge clk);
        check_off("vdd");
        @(posedge clk); #1 vdd = 0.80; din = 12'h2A5;
        @(posedge clk); #1 din_vld = 1'b0;
        @(posedge clk); @(negedge clk);
        check("vdd_rec_vld",   32'(dout_vld),  32'h1);
        check("vdd_rec_therm", 32'(datatherm), 32'h1F);

        // randomized run against the model
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rstb    = ($urandom_range(0, 399) != 0);
            din_vld = ($urandom_range(0, 3) != 0);
            din     = 12'($urandom_range(0, 4095));
            pdb     = ($urandom_range(0, 29) != 0);
            case ($urandom_range(0, 59))
                0:       vdd = 0.70;
                1:       vdd = 0.90;
                default: vdd = 0.80;
            endcase
        end
        @(posedge clk); #1 rstb = 1'b1; din_vld = 1'b0; pdb = 1'b1; vdd = 0.80;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
